// File: rtl/voting_machine_multi.sv
// N-candidate vote counter: debounced one-hot voting with multi-press rejection,
// saturating per-candidate counters and a sequential winner/tie tally on close.
module voting_machine_multi #(
    parameter  int N_CAND      = 4,
    parameter  int CNT_W       = 16,
    parameter  int HOLD_CYCLES = 1024,
    localparam int IDX_W       = $clog2(N_CAND)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CAND-1:0]       i_vote,
    input  logic                    i_voting_over,
    output logic [N_CAND*CNT_W-1:0] o_counts,
    output logic [CNT_W+IDX_W-1:0]  o_total,
    output logic                    o_ready,
    output logic                    o_rejected,
    output logic                    o_sat,
    output logic [IDX_W-1:0]        o_winner,
    output logic                    o_tie,
    output logic                    o_done
);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [IDX_W:0]    SCAN_END  = (IDX_W+1)'(N_CAND);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_HOLD,
        S_TALLY,
        S_DONE
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt [N_CAND];
    logic              prev_any;
    logic [HOLD_W-1:0] hold_cnt;
    logic [IDX_W:0]    scan;
    logic [CNT_W-1:0]  run_max;
    logic [IDX_W-1:0]  run_idx;
    logic              run_tie;

    logic              vote_any;
    logic              vote_onehot;
    logic [CNT_W-1:0]  sel_cnt;
    logic [CNT_W-1:0]  scan_cnt;

    // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        vote_any    = |i_vote;
        vote_onehot = vote_any && ((i_vote & (i_vote - N_CAND'(1))) == '0);
        sel_cnt     = '0;
        scan_cnt    = '0;
        for (int k = 0; k < N_CAND; k++) begin
            if (i_vote[k])
                sel_cnt = cnt[k];
            if (scan == (IDX_W+1)'(k))
                scan_cnt = cnt[k];
        end
    end

    always_comb begin
        o_counts = '0;
        for (int k = 0; k < N_CAND; k++)
            o_counts[k*CNT_W +: CNT_W] = cnt[k];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            prev_any   <= 1'b0;
            hold_cnt   <= '0;
            scan       <= '0;
            run_max    <= '0;
            run_idx    <= '0;
            run_tie    <= 1'b0;
            o_total    <= '0;
            o_ready    <= 1'b0;
            o_rejected <= 1'b0;
            o_sat      <= 1'b0;
            o_winner   <= '0;
            o_tie      <= 1'b0;
            o_done     <= 1'b0;
            // NOTE: the counter array is architectural state, so it is cleared on reset like any flop.
            for (int k = 0; k < N_CAND; k++)
                cnt[k] <= '0;
        end else begin
            prev_any   <= vote_any;
            o_rejected <= 1'b0;

            // Closing takes priority over any vote presented in the same cycle.
            if (i_voting_over && (state == S_IDLE || state == S_ARMED || state == S_HOLD)) begin
                state   <= S_TALLY;
                scan    <= '0;
                o_ready <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        state   <= S_ARMED;
                        o_ready <= 1'b1;
                    end

                    S_ARMED: begin
                        if (!prev_any && vote_any) begin
                            if (vote_onehot) begin
                                if (sel_cnt == CNT_MAX) begin
                                    o_sat <= 1'b1;
                                end else begin
                                    for (int k = 0; k < N_CAND; k++)
                                        if (i_vote[k])
                                            cnt[k] <= sel_cnt + CNT_W'(1);
                                    o_total <= o_total + (CNT_W+IDX_W)'(1);
                                end
                            end else begin
                                o_rejected <= 1'b1;
                            end
                            state    <= S_HOLD;
                            hold_cnt <= '0;
                            o_ready  <= 1'b0;
                        end
                    end

                    S_HOLD: begin
                        if (vote_any) begin
                            hold_cnt <= '0;
                        end else if (hold_cnt == HOLD_LAST) begin
                            state   <= S_ARMED;
                            o_ready <= 1'b1;
                        end else begin
                            hold_cnt <= hold_cnt + HOLD_W'(1);
                        end
                    end

                    S_TALLY: begin
                        if (scan == SCAN_END) begin
                            o_winner <= run_idx;
                            o_tie    <= run_tie;
                            o_done   <= 1'b1;
                            state    <= S_DONE;
                        end else begin
                            // Strict compare keeps the lowest index among equal maxima.
                            if (scan == '0) begin
                                run_max <= scan_cnt;
                                run_idx <= '0;
                                run_tie <= 1'b0;
                            end else if (scan_cnt > run_max) begin
                                run_max <= scan_cnt;
                                run_idx <= scan[IDX_W-1:0];
                                run_tie <= 1'b0;
                            end else if (scan_cnt == run_max) begin
                                run_tie <= 1'b1;
                            end
                            scan <= scan + (IDX_W+1)'(1);
                        end
                    end

                    S_DONE: ;

                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_voting_machine_multi.sv
// Scoreboard bench for voting_machine_multi: directed scenarios plus randomized
// voting, checked against a behavioural model of the voting rules.
module tb_voting_machine_multi;
    localparam int NC = 4;
    localparam int CW = 3;
    localparam int HC = 4;
    localparam int IW = $clog2(NC);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NC-1:0]     i_vote = '0;
    logic              i_voting_over = 1'b0;
    logic [NC*CW-1:0]  o_counts;
    logic [CW+IW-1:0]  o_total;
    logic              o_ready;
    logic              o_rejected;
    logic              o_sat;
    logic [IW-1:0]     o_winner;
    logic              o_tie;
    logic              o_done;

    voting_machine_multi #(.N_CAND(NC), .CNT_W(CW), .HOLD_CYCLES(HC)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_vote        (i_vote),
        .i_voting_over (i_voting_over),
        .o_counts      (o_counts),
        .o_total       (o_total),
        .o_ready       (o_ready),
        .o_rejected    (o_rejected),
        .o_sat         (o_sat),
        .o_winner      (o_winner),
        .o_tie         (o_tie),
        .o_done        (o_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    typedef enum int {EV_COUNT, EV_REJ, EV_DONE} ev_kind_t;
    typedef struct {
        ev_kind_t         kind;
        logic [NC*CW-1:0] counts;
        logic [CW+IW-1:0] total;
        logic             sat;
        logic [IW-1:0]    winner;
        logic             tie;
        int               cyc;
    } ev_t;
    ev_t sb[$];

    // Reference model: vote tallies plus the voter-visible readiness rules.
    int m_cnt[NC];
    int m_total;
    bit m_sat, m_fresh, m_ready, m_closed, m_prev_any;
    int m_quiet;
    bit exp_ready;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [NC*CW-1:0] pack_counts();
        logic [NC*CW-1:0] p;
        p = '0;
        for (int k = 0; k < NC; k++)
            p[k*CW +: CW] = CW'(m_cnt[k]);
        return p;
    endfunction

    function automatic ev_t make_ev(input ev_kind_t kind);
        ev_t e;
        e.kind   = kind;
        e.counts = pack_counts();
        e.total  = (CW+IW)'(m_total);
        e.sat    = m_sat;
        e.winner = '0;
        e.tie    = 1'b0;
        e.cyc    = 0;
        return e;
    endfunction

    task automatic model_reset();
        foreach (m_cnt[k]) m_cnt[k] = 0;
        m_total    = 0;
        m_sat      = 0;
        m_fresh    = 1;
        m_ready    = 0;
        m_closed   = 0;
        m_prev_any = 0;
        m_quiet    = 0;
        exp_ready  = 0;
        sb.delete();
    endtask

    task automatic model_close();
        ev_t e;
        int best, nbest, win;
        best = -1; nbest = 0; win = 0;
        for (int k = 0; k < NC; k++) begin
            if (m_cnt[k] > best) begin best = m_cnt[k]; win = k; end
        end
        for (int k = 0; k < NC; k++)
            if (m_cnt[k] == best) nbest++;
        m_closed = 1;
        m_ready  = 0;
        e = make_ev(EV_DONE);
        e.winner = IW'(win);
        e.tie    = (nbest > 1);
        e.cyc    = cyc + NC + 1;
        sb.push_back(e);
    endtask

    // One clock edge of the rules, with the inputs that edge sampled.
    task automatic model_step(input logic [NC-1:0] v, input logic ov);
        int ones, k_sel;
        ones = $countones(v);
        k_sel = 0;
        for (int k = 0; k < NC; k++) if (v[k]) k_sel = k;
        if (m_closed) begin
        end else if (m_fresh) begin
            m_fresh = 0;
            if (ov) model_close(); else m_ready = 1;
        end else if (ov) begin
            model_close();
        end else if (m_ready) begin
            if (!m_prev_any && ones == 1) begin
                if (m_cnt[k_sel] == (1 << CW) - 1) begin
                    if (!m_sat) begin m_sat = 1; sb.push_back(make_ev(EV_COUNT)); end
                end else begin
                    m_cnt[k_sel]++;
                    m_total++;
                    sb.push_back(make_ev(EV_COUNT));
                end
                m_ready = 0; m_quiet = 0;
            end else if (!m_prev_any && ones > 1) begin
                sb.push_back(make_ev(EV_REJ));
                m_ready = 0; m_quiet = 0;
            end
        end else begin
            if (ones > 0) m_quiet = 0; else m_quiet++;
            if (m_quiet == HC) m_ready = 1;
        end
        m_prev_any = (ones > 0);
        exp_ready  = m_ready && !m_closed;
    endtask

    task automatic cycle(input logic [NC-1:0] v, input logic ov);
        i_vote = v;
        i_voting_over = ov;
        @(posedge clk);
        #1;
        model_step(v, ov);
    endtask

    task automatic apply_reset();
        int stale;
        stale = 0;
        foreach (sb[i])
            if (!(sb[i].kind == EV_DONE && sb[i].cyc > cyc)) stale++;
        check("sb_stale_before_reset", stale, 0);
        rst = 1'b1;
        i_vote = '0;
        i_voting_over = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check("rst_counts", o_counts, 0);
        check("rst_total", o_total, 0);
        check("rst_flags", {o_ready, o_rejected, o_sat, o_tie, o_done}, 0);
        check("rst_winner", o_winner, 0);
    endtask

    task automatic vote_once(input int k);
        cycle(NC'(1 << k), 1'b0);
        repeat (HC) cycle('0, 1'b0);
    endtask

    function automatic logic [NC-1:0] rand_vote();
        int r;
        r = $urandom_range(0, 9);
        if (r < 5) return '0;
        if (r < 8) return NC'(1 << $urandom_range(0, NC - 1));
        return NC'($urandom_range(0, (1 << NC) - 1));
    endfunction

    task automatic pop_event(input ev_kind_t k, output ev_t e, output bit ok);
        ok = 0;
        e = make_ev(k);
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_event: got kind %0d, expected none (t=%0t)", int'(k), $time);
        end else begin
            e = sb.pop_front();
            check("event_kind", int'(k), int'(e.kind));
            ok = (e.kind == k);
        end
    endtask

    initial begin : monitor
        logic [NC*CW+CW+IW:0] snap, prev_snap;
        logic prev_done;
        ev_t  e;
        bit   ok;
        prev_snap = '0;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_snap = '0;
                prev_done = 1'b0;
            end else begin
                snap = {o_counts, o_total, o_sat};
                check("ready", o_ready, exp_ready);
                if (o_rejected)
                    pop_event(EV_REJ, e, ok);
                if (snap !== prev_snap) begin
                    pop_event(EV_COUNT, e, ok);
                    if (ok) begin
                        check("counts", o_counts, e.counts);
                        check("total", o_total, e.total);
                        check("sat", o_sat, e.sat);
                    end
                end
                if (o_done && !prev_done) begin
                    pop_event(EV_DONE, e, ok);
                    if (ok) begin
                        check("winner", o_winner, e.winner);
                        check("tie", o_tie, e.tie);
                        check("done_cycle", cyc, e.cyc);
                    end
                end
                prev_snap = snap;
                prev_done = o_done;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        n_checks++;
        n_errors++;
        $display("FAIL timeout: got no end of stimulus, expected finish within 1000000 ns");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : driver
        model_reset();
        apply_reset();

        // Long press for candidate 2, then debounce release.
        cycle('0, 1'b0);
        repeat (5) cycle(4'b0100, 1'b0);
        repeat (3) cycle('0, 1'b0);
        check("ready_before_hold_end", o_ready, 0);
        cycle('0, 1'b0);
        check("ready_after_hold", o_ready, 1);
        check("count2_after_press", o_counts[2*CW +: CW], 1);

        // Multi-press is rejected.
        cycle(4'b0011, 1'b0);
        check("reject_no_count", o_total, 1);
        repeat (HC) cycle('0, 1'b0);

        // Re-press during hold restarts the release window.
        cycle(4'b0010, 1'b0);
        repeat (2) cycle('0, 1'b0);
        cycle(4'b0010, 1'b0);
        repeat (HC - 1) cycle('0, 1'b0);
        check("hold_restarted", o_ready, 0);
        cycle('0, 1'b0);
        check("count1_once", o_counts[1*CW +: CW], 1);

        // Saturation with 9 votes on a 3-bit counter.
        apply_reset();
        cycle('0, 1'b0);
        repeat (9) vote_once(0);
        check("sat_count0", o_counts[0 +: CW], 7);
        check("sat_total", o_total, 7);
        check("sat_flag", o_sat, 1);

        // Counts {3,5,5,1}; close together with a cand3 press.
        apply_reset();
        cycle('0, 1'b0);
        repeat (3) vote_once(0);
        repeat (5) vote_once(1);
        repeat (5) vote_once(2);
        vote_once(3);
        cycle(4'b1000, 1'b1);
        repeat (NC + 3) cycle(4'b0001, 1'b0);
        check("close_cand3", o_counts[3*CW +: CW], 1);
        check("close_winner", o_winner, 1);
        check("close_tie", o_tie, 1);
        check("close_done", o_done, 1);

        // Close straight from IDLE: all-zero counts.
        apply_reset();
        cycle('0, 1'b1);
        repeat (NC + 2) cycle('0, 1'b0);

        // Reset on the second TALLY cycle.
        apply_reset();
        cycle('0, 1'b0);
        vote_once(2);
        cycle('0, 1'b1);
        cycle('0, 1'b0);
        apply_reset();
        check("midtally_ready_low", o_ready, 0);
        cycle('0, 1'b0);
        check("midtally_rearmed", o_ready, 1);

        // Randomized voting sessions.
        repeat (4) begin
            apply_reset();
            repeat (200) begin
                logic [NC-1:0] v;
                v = rand_vote();
                repeat ($urandom_range(1, 3)) cycle(v, 1'b0);
            end
            cycle(rand_vote(), 1'b1);
            repeat (NC + 4) cycle(rand_vote(), 1'b0);
        end

        repeat (2) cycle('0, 1'b0);
        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/voting_machine_multi.md
Name: voting_machine_multi

Overview:
- Parametrised successor to the three-candidate vote counter.
- Supports N candidates, configurable counter width and debounce hold length, and one-hot vote validation with rejection of multi-press.
- Counters saturate instead of wrapping.
- Closing the vote runs a sequential tally that reports the winner index and a tie flag.
- Sits behind the button-input conditioning logic. Drives the results display/readout.

Parameters:
- N_CAND, 4, number of candidates (2..16).
- CNT_W, 16, width of each per-candidate counter.
- HOLD_CYCLES, 1024, consecutive all-released cycles required before the next vote is accepted (>=1).
- IDX_W, $clog2(N_CAND), derived localparam; width of the candidate index.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- i_vote  input  N_CAND  vote buttons; bit k = candidate k.
- i_voting_over  input  1  level; closes voting.
- o_counts  output  N_CAND*CNT_W  packed counters; candidate k at [k*CNT_W +: CNT_W].
- o_total  output  CNT_W+IDX_W  total accepted votes.
- o_ready  output  1  high while in ARMED.
- o_rejected  output  1  one-cycle pulse on a multi-press.
- o_sat  output  1  sticky; a vote was discarded because its counter was at maximum.
- o_winner  output  IDX_W  winning candidate index; valid when o_done=1.
- o_tie  output  1  another candidate equals the maximum; valid when o_done=1.
- o_done  output  1  tally complete; held until rst.

Behaviour:
- Reset (synchronous, rst=1 at a clock edge):
  - state=IDLE.
  - All outputs, counters, hold counter and prev_any cleared to 0.
- prev_any register: holds |i_vote of the previous cycle. Updated every non-reset cycle.
- States: IDLE, ARMED, HOLD, TALLY, DONE.
- IDLE:
  - next cycle -> TALLY if i_voting_over=1, else -> ARMED.
- ARMED:
  - i_voting_over=1 has priority: -> TALLY. A vote presented in the same cycle is not counted.
  - Else, if i_vote is one-hot and prev_any=0:
    - counter k increments if below 2^CNT_W-1, and o_total increments in the same cycle.
    - if counter k is already at 2^CNT_W-1: no increments, o_sat set.
    - -> HOLD in either case.
  - Else, if i_vote has 2 or more bits set and prev_any=0: no count, o_rejected=1 for exactly one cycle, -> HOLD.
  - Else: stay in ARMED. A button already held on entry to ARMED (prev_any=1) is not counted until released and re-pressed.
  - Count latency: counter visible on the output the cycle after the accepting edge.
- HOLD:
  - hold counter clears whenever any i_vote bit is 1, and increments while i_vote=0.
  - -> ARMED on the cycle the counter reaches HOLD_CYCLES, i.e. after HOLD_CYCLES consecutive released cycles.
  - Presses in HOLD are never counted; they restart the hold.
  - i_voting_over=1 -> TALLY immediately.
- TALLY:
  - scans candidates 0..N_CAND-1, one per cycle, holding a running max and index.
  - strictly-greater comparison, so the lowest index wins among equals.
  - tie flag set if any later candidate equals the current max; cleared when a new strict max is found.
  - -> DONE after N_CAND cycles. o_done, o_winner and o_tie update on entry to DONE: exactly N_CAND+1 edges after the edge that entered TALLY.
  - all-zero counts -> winner 0; tie=1 when N_CAND>1.
- DONE:
  - absorbing state; only rst leaves it.
  - counts and total frozen; i_vote and i_voting_over ignored; o_ready=0.
- Reset in any state (including mid-TALLY or HOLD) returns to IDLE with every output at 0 on the following cycle.
- o_ready is a registered decode of state==ARMED.

Test Plan:
- HOLD_CYCLES=4, N_CAND=4: after reset, press i_vote=4'b0100 for 5 cycles, then release -> count2=1, total=1, o_ready low for the press cycles plus 4 release cycles, then high.
- i_vote=4'b0011 in ARMED -> o_rejected high for one cycle, all counts and total 0, FSM in HOLD.
- Accept vote for cand1; re-press cand1 after 2 released HOLD cycles -> count1 stays 1, hold restarts, ARMED returns 4 released cycles later.
- CNT_W=3: 9 separate votes for cand0 -> count0=7, total=7, o_sat=1 after the 8th vote.
- Counts {3,5,5,1}; assert i_voting_over together with a cand3 press -> cand3 stays 1; o_done=1 exactly 5 cycles after TALLY entry; o_winner=1, o_tie=1.
- Assert rst on the 2nd TALLY cycle -> next cycle all counts, total, o_done, o_tie and o_winner are 0, state IDLE, then ARMED on the following cycle.
